// File: rtl/mips_trace_buffer.sv
// Retire-trace capture for the multi-cycle MIPS core: circular log with PC trigger,
// post-trigger depth, freeze on halt and oldest-first readout. Timestamps: MIPS_TRACE_TIMESTAMP_EN.
module mips_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int POST_TRIG = 8,
   parameter int TS_W      = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            arm,
   input  logic            trig_en,
   input  logic [31:0]     trig_pc,
   input  logic            tr_valid,
   input  logic [31:0]     tr_pc,
   input  logic [31:0]     tr_inst,
   input  logic            tr_we,
   input  logic [4:0]      tr_waddr,
   input  logic [31:0]     tr_wdata,
   input  logic            halt_sig,
   input  logic            rd_en,
   output logic            rd_valid,
   output logic [31:0]     rd_pc,
   output logic [31:0]     rd_inst,
   output logic            rd_we,
   output logic [4:0]      rd_waddr,
   output logic [31:0]     rd_wdata,
   output logic [TS_W-1:0] rd_ts,
   output logic [AW:0]     count,
   output logic [1:0]      state,
   output logic            triggered,
   output logic            halted
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ARMED  = 2'd1;
   localparam logic [1:0] S_POST   = 2'd2;
   localparam logic [1:0] S_FROZEN = 2'd3;
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PT   = AW'(POST_TRIG);

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] inst_mem  [DEPTH];
   logic        we_mem    [DEPTH];
   logic [4:0]  waddr_mem [DEPTH];
   logic [31:0] wdata_mem [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr, post_cnt, wr_ptr_n;
   logic [AW:0]   remaining, count_n;
   logic [1:0]    state_n;
   logic          capturing, cap, fire, do_arm, do_read, go_frozen;

   always_comb begin
      capturing = (state == S_ARMED) || (state == S_POST);
      cap       = capturing && tr_valid;
      fire      = (state == S_ARMED) && tr_valid && trig_en && (tr_pc == trig_pc);
      do_arm    = arm && ((state == S_IDLE) || (state == S_FROZEN));
      do_read   = (state == S_FROZEN) && !arm && rd_en && (remaining != '0);
      wr_ptr_n  = cap ? wr_ptr + AW'(1) : wr_ptr;
      count_n   = (cap && count != FULL) ? count + (AW+1)'(1) : count;
      state_n   = state;
      if (do_arm) begin
         state_n = S_ARMED;
      end else if (capturing) begin
         if (fire)
            state_n = (POST_TRIG == 0) ? S_FROZEN : S_POST;
         else if (state == S_POST && cap && (post_cnt + AW'(1)) == PT)
            state_n = S_FROZEN;
         // halt overrides any trigger outcome this cycle
         if (halt_sig)
            state_n = S_FROZEN;
      end
      go_frozen = capturing && (state_n == S_FROZEN);
   end

   always_ff @(posedge clk) begin
      if (cap) begin
         pc_mem[wr_ptr]    <= tr_pc;
         inst_mem[wr_ptr]  <= tr_inst;
         we_mem[wr_ptr]    <= tr_we;
         waddr_mem[wr_ptr] <= tr_waddr;
         wdata_mem[wr_ptr] <= tr_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         post_cnt  <= '0;
         count     <= '0;
         remaining <= '0;
         triggered <= 1'b0;
         halted    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_pc     <= '0;
         rd_inst   <= '0;
         rd_we     <= 1'b0;
         rd_waddr  <= '0;
         rd_wdata  <= '0;
      end else begin
         state    <= state_n;
         rd_valid <= do_read;
         if (do_arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            count     <= '0;
            remaining <= '0;
            triggered <= 1'b0;
            halted    <= 1'b0;
         end else begin
            wr_ptr <= wr_ptr_n;
            count  <= count_n;
            if (fire) begin
               triggered <= 1'b1;
               post_cnt  <= '0;
            end else if (state == S_POST && cap) begin
               post_cnt <= post_cnt + AW'(1);
            end
            if (capturing && halt_sig)
               halted <= 1'b1;
            // oldest entry sits at wr_ptr once the buffer has wrapped
            if (go_frozen) begin
               rd_ptr    <= (count_n == FULL) ? wr_ptr_n : '0;
               remaining <= count_n;
            end
            if (do_read) begin
               rd_ptr    <= rd_ptr + AW'(1);
               remaining <= remaining - (AW+1)'(1);
               rd_pc     <= pc_mem[rd_ptr];
               rd_inst   <= inst_mem[rd_ptr];
               rd_we     <= we_mem[rd_ptr];
               rd_waddr  <= waddr_mem[rd_ptr];
               rd_wdata  <= wdata_mem[rd_ptr];
            end
         end
      end
   end

`ifdef MIPS_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] ts_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (cap)
         ts_mem[wr_ptr] <= ts;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts    <= '0;
         rd_ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (do_read)
            rd_ts <= ts_mem[rd_ptr];
      end
   end
`else
   assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Randomized scoreboard bench for mips_trace_buffer against a queue-based trace model.
module tb_mips_trace_buffer;
   localparam int DEPTH = 16, AW = 4, POST_TRIG = 8, TS_W = 32;

   logic clk = 0, reset = 0, arm = 0, trig_en = 0, tr_valid = 0, tr_we = 0, halt_sig = 0, rd_en = 0;
   logic [31:0] trig_pc = 0, tr_pc = 0, tr_inst = 0, tr_wdata = 0;
   logic [4:0]  tr_waddr = 0;
   logic rd_valid, rd_we, triggered, halted;
   logic [31:0] rd_pc, rd_inst, rd_wdata;
   logic [4:0]  rd_waddr;
   logic [TS_W-1:0] rd_ts;
   logic [AW:0] count;
   logic [1:0]  state;

   mips_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST_TRIG(POST_TRIG), .TS_W(TS_W)) dut (
      .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_inst(tr_inst), .tr_we(tr_we),
      .tr_waddr(tr_waddr), .tr_wdata(tr_wdata), .halt_sig(halt_sig), .rd_en(rd_en),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_we(rd_we),
      .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_ts(rd_ts), .count(count),
      .state(state), .triggered(triggered), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, inst, wd;
      logic we;
      logic [4:0] wa;
      logic [TS_W-1:0] ts;
   } ent_t;
   typedef struct { ent_t e; int due; } exp_t;

   ent_t q[$];      // everything captured since arm, oldest first, capped at DEPTH
   ent_t rq[$];     // entries still to be read out after freeze
   exp_t sb[$];
   exp_t mon_x;
   int m_st = 0, m_post = 0, cyc = 0;
   bit m_trig = 0, m_halt = 0;
   longint mts = 0;
   int total = 0, bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_x = sb.pop_front();
            chk("rd_valid", rd_valid, 1);
            chk("rd_pc", rd_pc, mon_x.e.pc);
            chk("rd_inst", rd_inst, mon_x.e.inst);
            chk("rd_we", rd_we, mon_x.e.we);
            chk("rd_waddr", rd_waddr, mon_x.e.wa);
            chk("rd_wdata", rd_wdata, mon_x.e.wd);
`ifdef MIPS_TRACE_TIMESTAMP_EN
            chk("rd_ts", rd_ts, mon_x.e.ts);
`else
            chk("rd_ts", rd_ts, 0);
`endif
         end else begin
            chk("rd_valid idle", rd_valid, 0);
         end
      end
   end

   // Advance the model by one clock using the current inputs, then clock the DUT.
   task automatic tick();
      ent_t e;
      exp_t x;
      int nxt;
      bit fire;
      if ((m_st == 0 || m_st == 3) && arm) begin
         q.delete(); rq.delete();
         m_trig = 0; m_halt = 0; m_post = 0; m_st = 1;
      end else if (m_st == 3) begin
         if (rd_en && rq.size() > 0) begin
            x.e = rq.pop_front();
            x.due = cyc + 1;
            sb.push_back(x);
         end
      end else if (m_st == 1 || m_st == 2) begin
         nxt = m_st;
         if (tr_valid) begin
            e.pc = tr_pc; e.inst = tr_inst; e.we = tr_we; e.wa = tr_waddr;
            e.wd = tr_wdata; e.ts = TS_W'(mts);
            q.push_back(e);
            if (q.size() > DEPTH) void'(q.pop_front());
         end
         fire = (m_st == 1) && tr_valid && trig_en && (tr_pc == trig_pc);
         if (fire) begin
            m_trig = 1; m_post = 0;
            nxt = (POST_TRIG == 0) ? 3 : 2;
         end else if (m_st == 2 && tr_valid) begin
            m_post++;
            if (m_post == POST_TRIG) nxt = 3;
         end
         if (halt_sig) begin
            m_halt = 1; nxt = 3;
         end
         if (nxt == 3) rq = q;
         m_st = nxt;
      end
      mts++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(string tag);
      chk({tag, " state"}, state, m_st);
      chk({tag, " count"}, count, q.size());
      chk({tag, " triggered"}, triggered, m_trig);
      chk({tag, " halted"}, halted, m_halt);
   endtask

   task automatic do_reset();
      reset = 1;
      #1;
      chk("rst state", state, 0);
      chk("rst count", count, 0);
      chk("rst rd_valid", rd_valid, 0);
      chk("rst rd_pc", rd_pc, 0);
      chk("rst triggered", triggered, 0);
      chk("rst halted", halted, 0);
      repeat (2) @(posedge clk);
      #1;
      arm = 0; tr_valid = 0; halt_sig = 0; rd_en = 0;
      reset = 0;
      q.delete(); rq.delete(); sb.delete();
      m_st = 0; m_trig = 0; m_halt = 0; m_post = 0; mts = 0;
   endtask

   task automatic ret(logic [31:0] pc, logic [31:0] inst, logic we, logic [4:0] wa, logic [31:0] wd);
      tr_valid = 1; tr_pc = pc; tr_inst = inst; tr_we = we; tr_waddr = wa; tr_wdata = wd;
      tick();
      tr_valid = 0;
   endtask

   task automatic ret_r(logic [31:0] pc);
      ret(pc, $urandom, 1'($urandom), 5'($urandom), $urandom);
   endtask

   task automatic do_arm();
      arm = 1; tick(); arm = 0;
   endtask

   task automatic read_n(int n, bit gaps);
      for (int i = 0; i < n; i++) begin
         rd_en = 1; tick(); rd_en = 0;
         if (gaps && $urandom_range(0, 2) == 0) tick();
      end
      tick();
   endtask

   initial begin
      #2;
      do_reset();

      // reset mid-capture
      do_arm();
      chk_status("armed");
      for (int k = 0; k < 5; k++) ret_r(32'h2000 + 4 * k);
      chk_status("cap5");
      do_reset();

      // wrap: 20 retires into 16 entries, then halt
      do_arm();
      for (int k = 0; k < 20; k++) ret_r(32'h3000 + 4 * k);
      halt_sig = 1; tick(); halt_sig = 0;
      chk_status("wrap");
      chk("wrap count16", count, 16);
      read_n(17, 0);
      chk_status("wrap read");

      // PC trigger with post-trigger depth
      trig_pc = 32'h3058; trig_en = 1;
      do_arm();
      for (int k = 0; k <= 32; k++) begin
         if ($urandom_range(0, 3) == 0) tick();
         ret_r(32'h3000 + 4 * k);
      end
      chk_status("trig");
      chk("trig state", state, 3);
      read_n(DEPTH + 1, 1);

      // halt and trigger in the same cycle
      do_arm();
      for (int k = 0; k <= 22; k++) begin
         if (k == 22) halt_sig = 1;
         ret_r(32'h3000 + 4 * k);
         halt_sig = 0;
      end
      chk_status("trig+halt");
      read_n(DEPTH + 1, 0);
      trig_en = 0;

      // exact field capture of an addu
      do_arm();
      tick(); tick();
      ret(32'h0040_0010, 32'h0109_4021, 1, 5'd8, 32'h0000_00FF);
      halt_sig = 1; tick(); halt_sig = 0;
      read_n(2, 0);

      // re-arm from FROZEN after a partial read; reads ignored while armed
      do_arm();
      for (int k = 0; k < 6; k++) ret_r(32'h5000 + 4 * k);
      halt_sig = 1; tick(); halt_sig = 0;
      read_n(2, 0);
      do_arm();
      chk_status("rearm");
      rd_en = 1; repeat (3) tick(); rd_en = 0;
      for (int k = 0; k < 4; k++) ret_r(32'h6000 + 4 * k);
      halt_sig = 1; tick(); halt_sig = 0;
      read_n(5, 0);

      // random traffic
      trig_pc = 32'h0000_010C;
      for (int i = 0; i < 1500; i++) begin
         arm      = ($urandom_range(0, 39) == 0);
         trig_en  = 1'($urandom);
         halt_sig = ($urandom_range(0, 59) == 0);
         rd_en    = 1'($urandom);
         tr_valid = 1'($urandom);
         tr_pc    = 32'h100 + 4 * $urandom_range(0, 7);
         tr_inst  = $urandom; tr_we = 1'($urandom);
         tr_waddr = 5'($urandom); tr_wdata = $urandom;
         tick();
         chk_status("rand");
      end
      arm = 0; trig_en = 0; halt_sig = 0; rd_en = 0; tr_valid = 0;
      repeat (3) tick();
      chk("scoreboard drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Synthesisable retire-trace capture unit for the multi-cycle MIPS core; replaces per-cycle console dumping with an on-chip circular log of retired instructions.
- Sits beside `mips`. Taps the retire strobe, PC, instruction word, GPR write port and `halt_sig`.
- Supports PC-match trigger with post-trigger depth, freeze on halt, and a sequential oldest-first readout port.

Parameters:
- DEPTH, 16, entries in circular buffer; power of two, >= 2.
- AW, 4, log2(DEPTH).
- POST_TRIG, 8, entries captured after the trigger entry before freezing; 0 to DEPTH-1.
- TS_W, 32, timestamp counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- arm  in  1  pulse: clear buffer and start capture.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  32  trigger PC value.
- tr_valid  in  1  one instruction retires this cycle.
- tr_pc  in  32  PC of the retiring instruction.
- tr_inst  in  32  instruction word.
- tr_we  in  1  GPR write enable.
- tr_waddr  in  5  GPR write address.
- tr_wdata  in  32  GPR write data.
- halt_sig  in  1  core halt indication.
- rd_en  in  1  read request; pops the oldest unread entry.
- rd_valid  out  1  read data valid; one-cycle pulse.
- rd_pc  out  32  entry PC.
- rd_inst  out  32  entry instruction word.
- rd_we  out  1  entry GPR write enable.
- rd_waddr  out  5  entry GPR write address.
- rd_wdata  out  32  entry GPR write data.
- rd_ts  out  TS_W  entry timestamp.
- count  out  AW+1  number of valid entries, 0..DEPTH.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN.
- triggered  out  1  sticky: trigger fired.
- halted  out  1  sticky: freeze was caused by halt.

Behaviour:
- Reset (async, any state, mid-capture or mid-read):
  - state=IDLE; all pointers and counters 0; count=0.
  - rd_valid=0; all rd_* = 0; triggered=0; halted=0.
  - Timestamp counter = 0.
- Timestamp: free-running, increments every clock, wraps at 2^TS_W.
- IDLE: no capture. arm -> ARMED next edge.
- arm in IDLE or FROZEN:
  - Clears wr_ptr, rd_ptr, count, post_cnt, triggered and halted.
  - Next state ARMED.
  - arm in ARMED or POST is ignored.
- Capture (ARMED or POST), when tr_valid=1:
  - Write {tr_pc, tr_inst, tr_we, tr_waddr, tr_wdata, ts} at wr_ptr; wr_ptr++ mod DEPTH.
  - count++ saturating at DEPTH. At DEPTH, the oldest entry is overwritten.
- Trigger (ARMED only):
  - Fires when tr_valid && trig_en && tr_pc==trig_pc.
  - The trigger entry is captured; triggered=1; post_cnt=0.
  - Next state POST, or FROZEN directly if POST_TRIG==0.
- POST: each captured entry increments post_cnt. The edge at which post_cnt reaches POST_TRIG enters FROZEN; that entry is captured.
- halt_sig=1 in ARMED or POST:
  - This cycle's tr_valid entry is captured; halted=1; next state FROZEN.
  - Halt and trigger in the same cycle: both flags set; FROZEN wins.
- FROZEN:
  - No capture.
  - On entry, rd_ptr = (count==DEPTH) ? wr_ptr : 0, i.e. the oldest entry; remaining = count.
- Read:
  - rd_en in FROZEN with remaining>0: next cycle rd_valid=1 with entry[rd_ptr]; rd_ptr++ mod DEPTH; remaining--.
  - rd_en with remaining==0, or outside FROZEN: rd_valid=0, no state change.
  - Back-to-back rd_en yields one entry per cycle.
  - rd_* hold their last value when rd_valid=0.
  - count reports captured entries and does not decrement on read.
- halt_sig while IDLE or FROZEN is ignored.

Optional Feature:
- Macro: MIPS_TRACE_TIMESTAMP_EN.
- Defined: the timestamp counter and per-entry TS_W storage exist; rd_ts returns the capture-cycle timestamp.
- Undefined: no counter and no storage; rd_ts is tied to 0. All other behaviour is identical.

Test Plan:
- Reset mid-capture: arm, 5 retires, assert reset -> state=0, count=0, rd_valid=0, triggered=0; re-arm works normally.
- Wrap, DEPTH=16: arm, 20 retires with pc=0x3000+4k (k=0..19), then halt_sig -> FROZEN, halted=1, count=16; 16 reads return pc 0x3010..0x304C in order; a 17th rd_en gives rd_valid=0.
- Trigger, POST_TRIG=8: trig_pc=0x3058, retire pc 0x3000..0x3080 step 4 -> FROZEN after pc 0x3078; last read entry pc=0x3078; triggered=1, halted=0.
- Same-cycle halt and trigger at pc 0x3058 -> FROZEN that edge; triggered=1, halted=1; last entry pc=0x3058.
- Field check: retire addu with we=1, waddr=8, wdata=0x0000_00FF, inst=0x0109_4021; halt -> read returns those exact fields. With MIPS_TRACE_TIMESTAMP_EN, rd_ts equals the cycle index of that retire; without it, rd_ts=0.
- Re-arm from FROZEN after a partial read -> count=0, state=ARMED, triggered=0, halted=0; rd_en ignored until FROZEN again.
